// File: rtl/seq_accum_adder.sv
// Sequential burst accumulator: sums unsigned operand beats until in_last,
// then holds the registered sum, beat count and sticky overflow until out_ready.
module seq_accum_adder #(
  parameter int WIDTH = 4,
  parameter int EXTRA = 1,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_last,
  input  logic                     sat_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH+EXTRA-1:0]   out_sum,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);

  localparam int ACC_W = WIDTH + EXTRA;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]       state_r, state_nxt_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             mode_r, mode_nxt_s;
  logic             accept_s;
  logic             load_out_s;
  logic [ACC_W:0]   sum_s;

  assign in_ready   = (state_r != ST_HOLD);
  assign out_valid  = (state_r == ST_HOLD);
  assign accept_s   = in_valid && in_ready;
  assign load_out_s = accept_s && in_last;
  assign sum_s      = {1'b0, acc_r} + {{(EXTRA + 1){1'b0}}, in_data};

  // Next-state and datapath update for one accepted beat or a HOLD release.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    count_nxt_s = count_r;
    ovf_nxt_s   = ovf_r;
    mode_nxt_s  = mode_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          // First beat seeds the burst; nothing from a previous burst survives.
          mode_nxt_s  = sat_en;
          acc_nxt_s   = {{EXTRA{1'b0}}, in_data};
          count_nxt_s = {{(CNT_W - 1){1'b0}}, 1'b1};
          ovf_nxt_s   = 1'b0;
          state_nxt_s = in_last ? ST_HOLD : ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (accept_s) begin
          ovf_nxt_s = ovf_r | sum_s[ACC_W];
          if (sum_s[ACC_W] && mode_r) begin
            acc_nxt_s = {ACC_W{1'b1}};
          end else begin
            acc_nxt_s = sum_s[ACC_W-1:0];
          end
          if (count_r == {CNT_W{1'b1}}) begin
            count_nxt_s = count_r;
          end else begin
            count_nxt_s = count_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          end
          state_nxt_s = in_last ? ST_HOLD : ST_ACCUM;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Burst state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      acc_r   <= {ACC_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

  // Result registers capture the final totals on the last-beat edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= {ACC_W{1'b0}};
      out_count <= {CNT_W{1'b0}};
      out_ovf   <= 1'b0;
    end else if (load_out_s) begin
      out_sum   <= acc_nxt_s;
      out_count <= count_nxt_s;
      out_ovf   <= ovf_nxt_s;
    end else begin
      out_sum   <= out_sum;
      out_count <= out_count;
      out_ovf   <= out_ovf;
    end
  end

endmodule

// File: tb/tb_seq_accum_adder.sv
// Randomized self-checking bench for seq_accum_adder against a burst-level
// reference model (list of accepted beats, totals computed on the last beat).
module tb_seq_accum_adder;
  localparam int WIDTH = 4;
  localparam int EXTRA = 1;
  localparam int CNT_W = 4;
  localparam int ACC_W = WIDTH + EXTRA;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  int errors = 0;
  int checks = 0;

  int beats[$];
  bit m_mode;
  bit m_hold;
  int e_sum;
  int e_cnt;
  bit e_ovf;

  always #5 clk = ~clk;

  seq_accum_adder #(.WIDTH(WIDTH), .EXTRA(EXTRA), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    beats.delete();
    m_mode = 1'b0;
    m_hold = 1'b0;
    e_sum  = 0;
    e_cnt  = 0;
    e_ovf  = 1'b0;
  endtask

  // Burst-level model: wrap keeps total mod 2^ACC_W, saturate clamps the total.
  task automatic model_edge();
    int total;
    if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      if (beats.size() == 0) m_mode = sat_en;
      beats.push_back(int'(in_data));
      if (in_last) begin
        total = 0;
        foreach (beats[i]) total += beats[i];
        e_cnt  = (beats.size() > CNT_MAX) ? CNT_MAX : beats.size();
        e_ovf  = (total > ACC_MAX);
        e_sum  = m_mode ? ((total > ACC_MAX) ? ACC_MAX : total) : (total % (ACC_MAX + 1));
        m_hold = 1'b1;
        beats.delete();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".in_ready"}, in_ready, !m_hold);
    check_val({tag, ".out_valid"}, out_valid, m_hold);
    if (m_hold) begin
      check_val({tag, ".out_sum"}, out_sum, e_sum);
      check_val({tag, ".out_count"}, out_count, e_cnt);
      check_val({tag, ".out_ovf"}, out_ovf, e_ovf);
    end
  endtask

  task automatic drive(input string tag, input logic v, input logic [WIDTH-1:0] d,
                       input logic l, input logic s, input logic r);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    sat_en    = s;
    out_ready = r;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst.in_ready", in_ready, 1'b1);
    check_val("rst.out_valid", out_valid, 1'b0);
    check_val("rst.out_sum", out_sum, 0);
    check_val("rst.out_count", out_count, 0);
    check_val("rst.out_ovf", out_ovf, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; sat_en = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Two-beat burst, latency one cycle.
    drive("b25a", 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    drive("b25b", 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    check_val("b25.sum", out_sum, 8);
    check_val("b25.count", out_count, 2);
    check_val("b25.ovf", out_ovf, 1'b0);
    drive("b25rel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Wrap on overflow.
    drive("b26a", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    drive("b26b", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    drive("b26c", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    check_val("b26.sum", out_sum, 13);
    check_val("b26.count", out_count, 3);
    check_val("b26.ovf", out_ovf, 1'b1);
    drive("b26rel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Saturation mode sampled on the first beat only.
    drive("b27a", 1'b1, 4'd15, 1'b0, 1'b1, 1'b0);
    drive("b27b", 1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
    drive("b27c", 1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    check_val("b27.sum", out_sum, 31);
    check_val("b27.ovf", out_ovf, 1'b1);

    // Hold with in_valid asserted: beat 7 must not be taken.
    for (int i = 0; i < 5; i++) begin
      drive("b28hold", 1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
      check_val("b28.in_ready", in_ready, 1'b0);
      check_val("b28.sum", out_sum, 31);
      check_val("b28.count", out_count, 3);
    end
    drive("b28rel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    check_val("b28.idle_valid", out_valid, 1'b0);
    check_val("b28.idle_ready", in_ready, 1'b1);

    // Reset mid-burst discards partial state.
    drive("b29a", 1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    drive("b29b", 1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive("b29c", 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    check_val("b29.sum", out_sum, 9);
    check_val("b29.count", out_count, 1);
    check_val("b29.ovf", out_ovf, 1'b0);
    drive("b29rel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Count saturation over a 17-beat burst.
    for (int i = 0; i < 17; i++) begin
      drive("b30", 1'b1, 4'd1, (i == 16), 1'b0, 1'b0);
    end
    check_val("b30.count", out_count, 15);
    check_val("b30.sum", out_sum, 17);
    check_val("b30.ovf", out_ovf, 1'b0);
    drive("b30rel", 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic with occasional resets and back-to-back bursts.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        drive("rand",
              ($urandom_range(0, 9) < 7),
              WIDTH'($urandom_range(0, (1 << WIDTH) - 1)),
              ($urandom_range(0, 5) == 0),
              $urandom_range(0, 1) == 1,
              ($urandom_range(0, 1) == 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
